div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Execute-stage issue/writeback controller that sits directly upstream of the integer divider.
- Accepts one decoded DIV/DIVU/REM/REMU request from EX and holds the operands stable.
- Drives the divider start/op/operand lines, retires the divider's result handshake, and presents the result to writeback with its rd tag.
- Produces the pipeline stall, handles flushes safely (no divider deadlock) and flags a hung divider via a watchdog.

Parameters:
- XLEN, 32, operand/result width.
- TIMEOUT_CYC, 64, cycles in RUN or DRAIN without div_res_valid_i before timeout_err_o sets.
- TCNT_W, 7, watchdog counter width; must satisfy 2^TCNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  EX presents a divide instruction
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_rs1_i  in  XLEN  dividend
- req_rs2_i  in  XLEN  divisor
- req_rd_i  in  5  destination register
- flush_i  in  1  pipeline flush/trap; kills the in-flight op
- stall_o  out  1  hold IF/ID/EX
- div_start_o  out  1  to divider start_i
- div_op_o  out  3  to divider op_i
- div_dividend_o  out  XLEN  to divider dividend_i
- div_divisor_o  out  XLEN  to divider divisor_i
- div_result_i  in  XLEN  from divider result_o
- div_res_valid_i  in  1  from divider res_valid_o
- div_res_ready_o  out  1  to divider res_ready_i
- wb_valid_o  out  1  result available for writeback
- wb_ready_i  in  1  writeback accepts
- wb_rd_o  out  5  destination tag
- wb_data_o  out  XLEN  quotient/remainder
- timeout_err_o  out  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous, active-low, on rst_n. All outputs reset to 0 except req_ready_o=1; the state machine resets to IDLE; op/operand/rd/data registers and the watchdog counter reset to 0.
- States: IDLE, RUN, WB, DRAIN.
- IDLE:
  - req_ready_o=1.
  - Accept when req_valid_i && !flush_i: latch op/rs1/rs2/rd, go to RUN.
  - flush_i in the same cycle: no accept, stay in IDLE.
- RUN:
  - div_start_o=1 continuously; operand/op outputs are the latched registers, constant for the whole op.
  - div_res_ready_o = div_res_valid_i (combinational, same cycle). This completes both divider handshake styles with start still high, so the divider clears valid and does not relaunch.
  - On div_res_valid_i: capture div_result_i into wb_data_o and go to WB. div_start_o falls on the next cycle.
- WB:
  - wb_valid_o=1; wb_rd_o/wb_data_o held stable until wb_ready_i.
  - On wb_ready_i: go to IDLE.
- DRAIN (entered on flush_i in RUN):
  - div_start_o stays 1 so a non-abortable divider still finishes.
  - div_res_ready_o = div_res_valid_i; the result is discarded; go to IDLE on div_res_valid_i.
  - No wb_valid_o. req_ready_o=0.
- flush_i in WB: drop the result, go to IDLE; wb_valid_o falls next cycle.
- flush_i in DRAIN/IDLE: no effect beyond the rules above.
- stall_o = (RUN) | (WB) | (IDLE & req_valid_i & !flush_i). stall_o is 0 in DRAIN: the flushed pipeline may refetch, but a new request is not accepted until IDLE.
- div_start_o is guaranteed low for at least 1 cycle between consecutive operations, because WB or the DRAIN→IDLE transition sits between them.
- req_ready_o=1 only in IDLE. Back-to-back throughput is divider latency + 2 cycles.
- Latency: request accepted at edge N → div_start_o high from N+1 → wb_valid_o high one cycle after the edge that sampled div_res_valid_i.
- Watchdog:
  - Counter clears on entering RUN or DRAIN and increments each cycle in those states.
  - Reaching TIMEOUT_CYC sets timeout_err_o, which is sticky until reset. The state machine keeps waiting; there is no forced exit.
- Divide-by-zero and signed overflow are the divider's responsibility; this block forwards the result unchanged.
- Reset mid-operation: all state is cleared immediately; div_start_o falls asynchronously.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5, wb_ready_i=1 → one wb_valid_o pulse, wb_rd_o=5, wb_data_o=0xFFFFFFFD. div_start_o is stable-high with constant operands until valid, then low.
- REMU 100/7 with wb_ready_i held low 10 cycles → wb_data_o=2 held stable, stall_o=1 and req_ready_o=0 throughout, single retire on the ready edge.
- DIVU x/0 → wb_data_o=0xFFFFFFFF. Then an immediate back-to-back REM 7/0 → wb_data_o=7. Check the div_start_o low gap of ≥1 cycle between them.
- flush_i asserted mid-RUN (bench divider with 33-cycle latency) → DRAIN, no wb_valid_o, stall_o=0. Divider result consumed via div_res_ready_o; next request is accepted only after IDLE and returns a correct result.
- flush_i in the same cycle as req_valid_i in IDLE → no accept, div_start_o stays 0. Separately, flush_i during WB → result dropped, return to IDLE.
- Bench divider never asserts valid → timeout_err_o=1 exactly TIMEOUT_CYC cycles after RUN entry, remains set. rst_n low mid-RUN → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-side issue/writeback sequencer for the iterative divider.
// Holds one DIV/REM op, drains it safely on flush and watches for a hung divider.
module div_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int TCNT_W      = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            div_start_o,
    output logic [2:0]      div_op_o,
    output logic [XLEN-1:0] div_dividend_o,
    output logic [XLEN-1:0] div_divisor_o,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            div_res_valid_i,
    output logic            div_res_ready_o,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            timeout_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [TCNT_W-1:0] TMAX = TCNT_W'(TIMEOUT_CYC);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   data_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic              terr_q;

    logic in_idle;
    logic in_run;
    logic in_wb;
    logic in_drain;
    logic busy;
    logic accept;
    logic to_drain;

    assign in_idle  = (state_q == S_IDLE);
    assign in_run   = (state_q == S_RUN);
    assign in_wb    = (state_q == S_WB);
    assign in_drain = (state_q == S_DRAIN);
    assign busy     = in_run | in_drain;
    assign accept   = in_idle & req_valid_i & ~flush_i;
    assign to_drain = in_run & flush_i & ~div_res_valid_i;

    // A flush that coincides with the result retires it here and skips DRAIN,
    // since the divider will not present another valid for this op.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            in_idle: begin
                if (accept) state_d = S_RUN;
            end
            in_run: begin
                if (div_res_valid_i) state_d = flush_i ? S_IDLE : S_WB;
                else if (flush_i)    state_d = S_DRAIN;
            end
            in_wb: begin
                if (flush_i || wb_ready_i) state_d = S_IDLE;
            end
            in_drain: begin
                if (div_res_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= req_op_i;
                rs1_q <= req_rs1_i;
                rs2_q <= req_rs2_i;
                rd_q  <= req_rd_i;
            end
            if (in_run && div_res_valid_i && !flush_i) begin
                data_q <= div_result_i;
            end
            // Watchdog saturates at TMAX so it cannot wrap and re-arm.
            if (accept || to_drain) begin
                tcnt_q <= '0;
            end else if (busy && tcnt_q != TMAX) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            if (busy && !div_res_valid_i && tcnt_q == TLIM) begin
                terr_q <= 1'b1;
            end
        end
    end

    assign req_ready_o     = in_idle;
    assign stall_o         = in_run | in_wb | accept;
    assign div_start_o     = busy;
    assign div_op_o        = op_q;
    assign div_dividend_o  = rs1_q;
    assign div_divisor_o   = rs2_q;
    assign div_res_ready_o = busy & div_res_valid_i;
    assign wb_valid_o      = in_wb;
    assign wb_rd_o         = rd_q;
    assign wb_data_o       = data_q;
    assign timeout_err_o   = terr_q;

endmodule
